// File: rtl/alu_issue_stage_pkg.sv
// ============================================================================
// alu_issue_stage_pkg : shared ALU op codes, control classes, funct fields,
// FSM encoding and the stored entry type.     rev 1.0
// ============================================================================
`default_nettype none

package alu_issue_stage_pkg;

   localparam logic [3:0] C_OP_AND = 4'b0000;
   localparam logic [3:0] C_OP_OR  = 4'b0001;
   localparam logic [3:0] C_OP_ADD = 4'b0010;
   localparam logic [3:0] C_OP_SUB = 4'b0110;
   localparam logic [3:0] C_OP_SLT = 4'b0111;
   localparam logic [3:0] C_OP_NOR = 4'b1100;

   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] C_ALUOP_OR    = 2'b11;

   localparam logic [5:0] C_FUNCT_ADD = 6'b100000;
   localparam logic [5:0] C_FUNCT_SUB = 6'b100010;
   localparam logic [5:0] C_FUNCT_AND = 6'b100100;
   localparam logic [5:0] C_FUNCT_OR  = 6'b100101;
   localparam logic [5:0] C_FUNCT_SLT = 6'b101010;
   localparam logic [5:0] C_FUNCT_NOR = 6'b100111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  operation;
      logic        illegal;
   } entry_t;

   localparam entry_t C_ENTRY_ZERO = '{a: 32'd0, b: 32'd0, operation: 4'd0, illegal: 1'b0};

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_decode.sv
// ============================================================================
// alu_control_decode : combinational ALU control, maps aluop/funct to a
// 4-bit operation and flags undecodable R-type funct values.     rev 1.0
// ============================================================================
`default_nettype none

module alu_control_decode
   import alu_issue_stage_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] operation,
   output logic       illegal
);

   always_comb begin
      operation = C_OP_AND;
      illegal   = 1'b0;
      case (aluop)
         C_ALUOP_ADD: operation = C_OP_ADD;
         C_ALUOP_SUB: operation = C_OP_SUB;
         C_ALUOP_OR:  operation = C_OP_OR;
         default: begin
            case (funct)
               C_FUNCT_ADD: operation = C_OP_ADD;
               C_FUNCT_SUB: operation = C_OP_SUB;
               C_FUNCT_AND: operation = C_OP_AND;
               C_FUNCT_OR:  operation = C_OP_OR;
               C_FUNCT_SLT: operation = C_OP_SLT;
               C_FUNCT_NOR: operation = C_OP_NOR;
               // unknown funct still issues, tagged so EX can trap it
               default:     illegal   = 1'b1;
            endcase
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : decodes ALU control and buffers requests in a two-entry
// (main + skid) registered handshake stage.     rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
   import alu_issue_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [1:0]  in_aluop,
   input  logic [5:0]  in_funct,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [3:0]  out_operation,
   output logic        out_illegal,
   output logic [15:0] issue_count
);

   logic [3:0]  dec_operation;
   logic        dec_illegal;
   entry_t      new_entry;

   state_e      state_q,     state_d;
   entry_t      main_q,      main_d;
   entry_t      skid_q,      skid_d;
   logic        in_ready_q,  in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] count_q,     count_d;

   logic        in_fire;
   logic        out_fire;

   alu_control_decode u_decode (
      .aluop     (in_aluop),
      .funct     (in_funct),
      .operation (dec_operation),
      .illegal   (dec_illegal)
   );

   always_comb begin
      new_entry.a         = in_a;
      new_entry.b         = in_b;
      new_entry.operation = dec_operation;
      new_entry.illegal   = dec_illegal;
   end

   // handshakes use only registered flags on this side
   assign in_fire  = in_valid  & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = new_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_d = new_entry;
            end else if (in_fire) begin
               skid_d  = new_entry;
               state_d = ST_TWO;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
      count_d     = count_q + {15'd0, out_fire};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= C_ENTRY_ZERO;
         skid_q      <= C_ENTRY_ZERO;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         count_q     <= 16'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_a         = main_q.a;
   assign out_b         = main_q.b;
   assign out_operation = main_q.operation;
   assign out_illegal   = main_q.illegal;
   assign issue_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// tb_alu_issue_stage : directed self-checking bench for alu_issue_stage.
// rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [1:0]  in_aluop;
   logic [5:0]  in_funct;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [3:0]  out_operation;
   logic        out_illegal;
   logic [15:0] issue_count;

   int total = 0;
   int bad   = 0;

   alu_issue_stage dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_aluop      (in_aluop),
      .in_funct      (in_funct),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_a         (out_a),
      .out_b         (out_b),
      .out_operation (out_operation),
      .out_illegal   (out_illegal),
      .issue_count   (issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected decode, written straight from the operation table
   function automatic logic [4:0] exp_dec(input logic [1:0] op, input logic [5:0] fn);
      case (op)
         2'b00: return {4'b0010, 1'b0};
         2'b01: return {4'b0110, 1'b0};
         2'b11: return {4'b0001, 1'b0};
         default: begin
            case (fn)
               6'b100000: return {4'b0010, 1'b0};
               6'b100010: return {4'b0110, 1'b0};
               6'b100100: return {4'b0000, 1'b0};
               6'b100101: return {4'b0001, 1'b0};
               6'b101010: return {4'b0111, 1'b0};
               6'b100111: return {4'b1100, 1'b0};
               default:   return {4'b0000, 1'b1};
            endcase
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_a = 32'h1111; in_b = 32'h2222; in_aluop = 2'b00; in_funct = 6'd0;
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || issue_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_flags: got valid=%b ready=%b cnt=%h want 0 1 0000", out_valid, in_ready, issue_count);
      end
      total++;
      if (out_a !== 32'd0 || out_b !== 32'd0 || out_operation !== 4'd0 || out_illegal !== 1'b0) begin
         bad++;
         $display("FAIL reset_data: got a=%h b=%h op=%b ill=%b want zeros", out_a, out_b, out_operation, out_illegal);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_edge_no_xfer: got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'd5; in_b = 32'd3; in_aluop = 2'b10; in_funct = 6'b100010;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_operation !== 4'b0110 || out_a !== 32'd5 || out_b !== 32'd3) begin
         bad++;
         $display("FAIL single_out: got v=%b op=%b a=%0d b=%0d want 1 0110 5 3", out_valid, out_operation, out_a, out_b);
      end
      tick();
      total++;
      if (issue_count !== 16'd1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_count: got cnt=%0d v=%b want 1 0", issue_count, out_valid);
      end
   endtask

   task automatic test_decode();
      logic [1:0] ops [10];
      logic [5:0] fns [10];
      ops = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      fns = '{6'b111111, 6'b000000, 6'b100010, 6'b100000, 6'b100010, 6'b100100,
              6'b100101, 6'b101010, 6'b100111, 6'b111111};
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [4:0] e;
         e = exp_dec(ops[i], fns[i]);
         in_valid = 1'b1; in_a = 32'(i); in_b = 32'(i + 100);
         in_aluop = ops[i]; in_funct = fns[i];
         tick();
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || {out_operation, out_illegal} !== e || out_a !== 32'(i)) begin
            bad++;
            $display("FAIL decode_%0d: got v=%b op=%b ill=%b a=%0d want 1 %b %b %0d",
                     i, out_valid, out_operation, out_illegal, out_a, e[4:1], e[0], i);
         end
         tick();
      end
   endtask

   task automatic test_illegal();
      logic [15:0] c0;
      c0 = issue_count;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'hDEAD; in_b = 32'hBEEF; in_aluop = 2'b10; in_funct = 6'b000000;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_operation !== 4'b0000 || out_illegal !== 1'b1) begin
         bad++;
         $display("FAIL illegal_out: got v=%b op=%b ill=%b want 1 0000 1", out_valid, out_operation, out_illegal);
      end
      tick();
      total++;
      if (issue_count !== c0 + 16'd1) begin
         bad++;
         $display("FAIL illegal_issued: got cnt=%0d want %0d", issue_count, c0 + 16'd1);
      end
   endtask

   task automatic test_backpressure();
      pulse_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 32'hA; in_b = 32'hA0; in_aluop = 2'b00; in_funct = 6'd0;
      tick();
      in_a = 32'hB; in_b = 32'hB0; in_aluop = 2'b01;
      tick();
      in_a = 32'hC; in_b = 32'hC0; in_aluop = 2'b11;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 32'hA || out_operation !== 4'b0010) begin
         bad++;
         $display("FAIL bp_two: got rdy=%b v=%b a=%h op=%b want 0 1 a 0010", in_ready, out_valid, out_a, out_operation);
      end
      tick();
      total++;
      if (in_ready !== 1'b0 || out_a !== 32'hA || out_b !== 32'hA0) begin
         bad++;
         $display("FAIL bp_hold: got rdy=%b a=%h b=%h want 0 a a0", in_ready, out_a, out_b);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_a !== 32'hB || out_operation !== 4'b0110 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_second: got v=%b a=%h op=%b rdy=%b want 1 b 0110 1", out_valid, out_a, out_operation, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || issue_count !== 16'd2) begin
         bad++;
         $display("FAIL bp_drain: got v=%b cnt=%0d want 0 2", out_valid, issue_count);
      end
   endtask

   task automatic test_stream();
      logic [68:0] q[$];
      logic [68:0] exp_e;
      logic [5:0]  fn_tab [8];
      int sent = 0;
      int got  = 0;
      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                 6'b101010, 6'b100111, 6'b000001, 6'b110000};
      pulse_reset();
      for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
         in_valid  = (sent < 100);
         in_a      = 32'hA000_0000 + 32'(sent);
         in_b      = 32'(sent * 7);
         in_aluop  = 2'(sent % 4);
         in_funct  = fn_tab[sent % 8];
         out_ready = 1'($urandom_range(0, 1));
         #3;
         if (in_valid && in_ready) begin
            q.push_back({in_a, in_b, exp_dec(in_aluop, in_funct)});
            sent++;
         end
         if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL stream_extra: got a=%h with nothing outstanding", out_a);
            end else begin
               exp_e = q.pop_front();
               if ({out_a, out_b, out_operation, out_illegal} !== exp_e) begin
                  bad++;
                  $display("FAIL stream_%0d: got %h want %h", got, {out_a, out_b, out_operation, out_illegal}, exp_e);
               end
            end
            got++;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++;
      if (got != 100) begin
         bad++;
         $display("FAIL stream_timeout: got %0d outputs want 100", got);
      end
      total++;
      if (issue_count !== 16'd100) begin
         bad++;
         $display("FAIL stream_count: got %0d want 100", issue_count);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2; in_aluop = 2'b00;
      tick();
      out_ready = 1'b0;
      in_a = 32'h3;
      tick();
      in_a = 32'h4;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || issue_count !== 16'd0 || out_a !== 32'd0) begin
         bad++;
         $display("FAIL rstmid_async: got v=%b rdy=%b cnt=%0d a=%h want 0 1 0 0", out_valid, in_ready, issue_count, out_a);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'h77; in_b = 32'h88; in_aluop = 2'b11;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_a !== 32'h77 || out_operation !== 4'b0001) begin
         bad++;
         $display("FAIL rstmid_after: got v=%b a=%h op=%b want 1 77 0001", out_valid, out_a, out_operation);
      end
      tick();
      total++;
      if (issue_count !== 16'd1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_count: got cnt=%0d v=%b want 1 0", issue_count, out_valid);
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      pulse_reset();
      in_aluop = 2'b00;
      for (int cyc = 0; cyc < 70000 && n < 65536; cyc++) begin
         if (n == 65535) begin
            total++;
            if (issue_count !== 16'hFFFF) begin
               bad++;
               $display("FAIL wrap_max: got %h want ffff", issue_count);
            end
         end
         in_valid = 1'b1;
         out_ready = 1'b1;
         in_a = 32'(cyc);
         #3;
         if (out_valid && out_ready) n++;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++;
      if (n != 65536 || issue_count !== 16'h0000) begin
         bad++;
         $display("FAIL wrap_zero: got n=%0d cnt=%h want 65536 0000", n, issue_count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_decode();
      test_illegal();
      test_backpressure();
      test_stream();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Ports SHALL be as follows; clock and reset come first:
- clk  input  1  — single clock, rising edge.
- rst  input  1  — asynchronous, active-high reset.
- in_valid  input  1  — upstream request valid.
- in_ready  output  1  — the stage can accept a request.
- in_a  input  32  — operand A.
- in_b  input  32  — operand B.
- in_aluop  input  2  — main-control ALU class.
- in_funct  input  6  — R-type function field.
- out_valid  output  1  — the issued entry is valid.
- out_ready  input  1  — the downstream ALU/EX stage accepts.
- out_a  output  32  — registered operand A.
- out_b  output  32  — registered operand B.
- out_operation  output  4  — 4-bit ALU operation code.
- out_illegal  output  1  — the entry had an undecodable funct.
- issue_count  output  16  — count of completed output handshakes.

REQ-002 The block SHALL use exactly one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-003 A transfer SHALL occur on a clk edge when valid and ready are both high on the same side; there is no other transfer condition.
REQ-004 Decode SHALL be combinational on the input side and SHALL be stored with the entry:
- in_aluop 00 -> 0010 (add).
- in_aluop 01 -> 0110 (sub).
- in_aluop 11 -> 0001 (or).
- in_aluop 10 -> decode by in_funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
REQ-005 With in_aluop 10 and any other in_funct, the entry SHALL be stored with operation 0000 and illegal 1; the entry SHALL still be issued and not dropped.
REQ-006 Storage SHALL be two entries: a main output register and a skid register, each holding a, b, operation and illegal.
REQ-007 The state machine SHALL have three states: EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-008 Transitions SHALL be as follows:
- EMPTY + in transfer -> ONE.
- ONE + in transfer only -> TWO.
- ONE + out transfer only -> EMPTY.
- ONE + both -> ONE, with main replaced by the new entry.
- TWO + out transfer -> ONE, with skid moving to main.
- Every other condition -> hold.
REQ-009 in_ready SHALL be 1 exactly when the state is not TWO, and SHALL be driven from a register, with no combinational path from out_ready.
REQ-010 out_valid SHALL be 1 exactly when the state is ONE or TWO; out_* SHALL always reflect the main register.
REQ-011 Latency SHALL be one cycle: a request accepted at edge N appears on out_* after edge N when the state was EMPTY.
REQ-012 Order SHALL be strictly FIFO, with no loss and no duplication under any valid/ready pattern.
REQ-013 While out_valid is 1 and out_ready is 0, out_* SHALL remain stable.
REQ-014 In state TWO, in_valid SHALL be ignored and no data SHALL change.
REQ-015 issue_count SHALL increment by 1 on each output transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-016 Input changes while in_ready is 0 SHALL have no effect.

Reset
REQ-017 rst SHALL asynchronously force:
- state EMPTY, so out_valid = 0 and in_ready = 1.
- issue_count = 0.
- out_a, out_b and out_operation = 0; out_illegal = 0.
- the skid register cleared.
REQ-018 Reset asserted mid-operation SHALL discard all held entries; the first accepted request after release SHALL be treated as from EMPTY.
REQ-019 A transfer SHALL NOT occur on the first clk edge coincident with rst still high.

Structure
REQ-020 A shared package SHALL hold:
- the ALU operation constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100).
- the aluop class constants.
- the funct constants.
- the state encoding.
REQ-021 Decode SHALL be a separate combinational sub-module, alu_control_decode (inputs aluop and funct; outputs operation and illegal); alu_issue_stage SHALL instantiate it once.

Verification
REQ-022 Reset, then one request with out_ready held 1:
- stimulus: a=5, b=3, aluop=10, funct=100010.
- response: next cycle out_valid=1, out_operation=0110, out_a=5, out_b=3; issue_count=1 after that transfer.
REQ-023 Back-pressure:
- stimulus: out_ready=0; send A (aluop 00), then B (aluop 01).
- response: state TWO and in_ready=0; out_* holds A; raising out_ready yields A then B on consecutive cycles.
REQ-024 Illegal funct:
- stimulus: aluop=10, funct=000000.
- response: out_operation=0000, out_illegal=1, entry issued.
REQ-025 Streaming:
- stimulus: 100 back-to-back requests with random out_ready.
- response: output sequence identical to input sequence; issue_count=100.
REQ-026 Reset mid-operation:
- stimulus: state TWO, assert rst for one cycle.
- response: out_valid=0 immediately, in_ready=1, issue_count=0; the next request issues normally.
REQ-027 Counter wrap:
- stimulus: preload via 65536 transfers.
- response: issue_count reads 0x0000.
